// File: rtl/lab4_net_channel_credit_tracker.sv
// lab4_net_channel_credit_tracker
//   Tracks free entries in the input queues of both ring neighbours. For each
//   channel (forward / backward) a counter starts at p_num_entries, goes down
//   on every flit we send and up on every credit the neighbour returns. The
//   neighbour's own advertised free count is registered alongside it so the
//   congestion logic sees a two-hop view of the ring.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   forw_send / backw_send     flit accepted onto the channel this cycle
//   forw_credit / backw_credit neighbour dequeued one entry this cycle
//   *_adv_val, *_adv_free      neighbour's advertised free_one count and its valid
//   *_free_one                 free entries in the neighbour queue (registered)
//   *_free_two                 last valid advertised count, clamped (registered)
//   *_can_send                 *_free_one != 0
//   err                        sticky: [0] send at zero, [1] credit at max
module lab4_net_channel_credit_tracker #(
  parameter int p_num_entries = 2,
  parameter int f             = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         forw_send,
  input  logic         forw_credit,
  input  logic         forw_adv_val,
  input  logic [f-1:0] forw_adv_free,
  input  logic         backw_send,
  input  logic         backw_credit,
  input  logic         backw_adv_val,
  input  logic [f-1:0] backw_adv_free,
  output logic [f-1:0] forw_free_one,
  output logic [f-1:0] forw_free_two,
  output logic [f-1:0] backw_free_one,
  output logic [f-1:0] backw_free_two,
  output logic         forw_can_send,
  output logic         backw_can_send,
  output logic [1:0]   err
);

  localparam logic [f-1:0] c_max  = f'(p_num_entries);
  localparam logic [f-1:0] c_zero = {f{1'b0}};
  localparam logic [f-1:0] c_one  = {{(f-1){1'b0}}, 1'b1};

  // Next counter value; a simultaneous send and credit cancel out, so the
  // count only moves when exactly one of them is present, and it saturates.
  function automatic logic [f-1:0] cnt_next(input logic [f-1:0] cnt,
                                            input logic         send,
                                            input logic         credit);
    logic [f-1:0] res;
    res = cnt;
    case ({send, credit})
      2'b10: begin
        if (cnt != c_zero) res = cnt - c_one;
        else               res = cnt;
      end
      2'b01: begin
        if (cnt != c_max) res = cnt + c_one;
        else              res = cnt;
      end
      default: res = cnt;
    endcase
    return res;
  endfunction

  // Error flags for one channel: {credit at max, send at zero}.
  function automatic logic [1:0] cnt_err(input logic [f-1:0] cnt,
                                         input logic         send,
                                         input logic         credit);
    logic [1:0] res;
    res = 2'b00;
    case ({send, credit})
      2'b10:   res = {1'b0, (cnt == c_zero)};
      2'b01:   res = {(cnt == c_max), 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // A neighbour can never have more free slots than the queue depth.
  function automatic logic [f-1:0] adv_clamp(input logic [f-1:0] adv);
    logic [f-1:0] res;
    if (adv > c_max) res = c_max;
    else             res = adv;
    return res;
  endfunction

  logic [f-1:0] forw_cnt_r,  forw_cnt_s;
  logic [f-1:0] backw_cnt_r, backw_cnt_s;
  logic [f-1:0] forw_two_r,  forw_two_s;
  logic [f-1:0] backw_two_r, backw_two_s;
  logic [1:0]   err_r,       err_s;

  // Next-state computation for counters, advertised counts and sticky errors.
  always_comb begin
    forw_cnt_s  = cnt_next(forw_cnt_r,  forw_send,  forw_credit);
    backw_cnt_s = cnt_next(backw_cnt_r, backw_send, backw_credit);
    if (forw_adv_val) forw_two_s = adv_clamp(forw_adv_free);
    else              forw_two_s = forw_two_r;
    if (backw_adv_val) backw_two_s = adv_clamp(backw_adv_free);
    else               backw_two_s = backw_two_r;
    err_s = err_r
          | cnt_err(forw_cnt_r,  forw_send,  forw_credit)
          | cnt_err(backw_cnt_r, backw_send, backw_credit);
  end

  // State registers; reset drops everything back to a full, error-free view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      forw_cnt_r  <= c_max;
      backw_cnt_r <= c_max;
      forw_two_r  <= c_max;
      backw_two_r <= c_max;
      err_r       <= 2'b00;
    end else begin
      forw_cnt_r  <= forw_cnt_s;
      backw_cnt_r <= backw_cnt_s;
      forw_two_r  <= forw_two_s;
      backw_two_r <= backw_two_s;
      err_r       <= err_s;
    end
  end

  assign forw_free_one  = forw_cnt_r;
  assign backw_free_one = backw_cnt_r;
  assign forw_free_two  = forw_two_r;
  assign backw_free_two = backw_two_r;
  assign forw_can_send  = (forw_cnt_r  != c_zero);
  assign backw_can_send = (backw_cnt_r != c_zero);
  assign err            = err_r;

endmodule

// File: tb/tb_lab4_net_channel_credit_tracker.sv
module tb_lab4_net_channel_credit_tracker;

  localparam int n_ent = 2;

  logic       clk;
  logic       reset;
  logic       forw_send, forw_credit, forw_adv_val;
  logic [1:0] forw_adv_free;
  logic       backw_send, backw_credit, backw_adv_val;
  logic [1:0] backw_adv_free;
  logic [1:0] forw_free_one, forw_free_two, backw_free_one, backw_free_two;
  logic       forw_can_send, backw_can_send;
  logic [1:0] err;

  int n_checks = 0;
  int n_fail   = 0;

  lab4_net_channel_credit_tracker #(.p_num_entries(2), .f(2)) dut (
    .clk(clk), .reset(reset),
    .forw_send(forw_send), .forw_credit(forw_credit),
    .forw_adv_val(forw_adv_val), .forw_adv_free(forw_adv_free),
    .backw_send(backw_send), .backw_credit(backw_credit),
    .backw_adv_val(backw_adv_val), .backw_adv_free(backw_adv_free),
    .forw_free_one(forw_free_one), .forw_free_two(forw_free_two),
    .backw_free_one(backw_free_one), .backw_free_two(backw_free_two),
    .forw_can_send(forw_can_send), .backw_can_send(backw_can_send),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {ffo, fft, bfo, bft, fcs, bcs, err}
  function automatic logic [11:0] obs();
    return {forw_free_one, forw_free_two, backw_free_one, backw_free_two,
            forw_can_send, backw_can_send, err};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got ffo/fft/bfo/bft/fcs/bcs/err=%03h, expected %03h", name, act, expv);
    end
  endtask

  typedef struct {
    logic       fs, fc, fav;
    logic [1:0] faf;
    logic       bs, bc, bav;
    logic [1:0] baf;
    logic [11:0] expv;
  } vec_t;

  function automatic vec_t mk(input logic fs, input logic fc, input logic fav, input logic [1:0] faf,
                              input logic bs, input logic bc, input logic bav, input logic [1:0] baf,
                              input logic [1:0] ffo, input logic [1:0] fft,
                              input logic [1:0] bfo, input logic [1:0] bft,
                              input logic fcs, input logic bcs, input logic [1:0] e);
    vec_t v;
    v.fs = fs; v.fc = fc; v.fav = fav; v.faf = faf;
    v.bs = bs; v.bc = bc; v.bav = bav; v.baf = baf;
    v.expv = {ffo, fft, bfo, bft, fcs, bcs, e};
    return v;
  endfunction

  task automatic drive(input logic fs, input logic fc, input logic fav, input logic [1:0] faf,
                       input logic bs, input logic bc, input logic bav, input logic [1:0] baf);
    forw_send = fs; forw_credit = fc; forw_adv_val = fav; forw_adv_free = faf;
    backw_send = bs; backw_credit = bc; backw_adv_val = bav; backw_adv_free = baf;
  endtask

  // Reference model: plain integer bookkeeping of free slots.
  int m_fcnt, m_bcnt, m_ftwo, m_btwo;
  logic [1:0] m_err;

  task automatic model_reset();
    m_fcnt = n_ent; m_bcnt = n_ent; m_ftwo = n_ent; m_btwo = n_ent; m_err = 2'b00;
  endtask

  task automatic model_chan(inout int cnt, input logic s, input logic c);
    int nc;
    nc = cnt + int'(c) - int'(s);
    if (nc < 0) begin
      m_err[0] = 1'b1;
      nc = 0;
    end else if (nc > n_ent) begin
      m_err[1] = 1'b1;
      nc = n_ent;
    end
    cnt = nc;
  endtask

  task automatic model_step(input logic fs, input logic fc, input logic fav, input logic [1:0] faf,
                            input logic bs, input logic bc, input logic bav, input logic [1:0] baf);
    model_chan(m_fcnt, fs, fc);
    model_chan(m_bcnt, bs, bc);
    if (fav) m_ftwo = (int'(faf) > n_ent) ? n_ent : int'(faf);
    if (bav) m_btwo = (int'(baf) > n_ent) ? n_ent : int'(baf);
  endtask

  function automatic logic [11:0] model_exp();
    return {2'(m_fcnt), 2'(m_ftwo), 2'(m_bcnt), 2'(m_btwo),
            (m_fcnt != 0), (m_bcnt != 0), m_err};
  endfunction

  vec_t vecs[17];

  initial begin
    //             fs fc fav faf   bs bc bav baf   ffo fft bfo bft fcs bcs err
    vecs[0]  = mk(0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 1, 1, 2'b00);
    vecs[1]  = mk(0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 1, 1, 2'b00);
    vecs[2]  = mk(0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 1, 1, 2'b00);
    vecs[3]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 1, 1, 2'b00);
    vecs[4]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1, 2'b00);
    vecs[5]  = mk(1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1, 2'b00);
    vecs[6]  = mk(0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 1, 1, 2'b00);
    vecs[7]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1, 2'b00);
    vecs[8]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1, 2'b01);
    vecs[9]  = mk(0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1, 2'b11);
    vecs[10] = mk(0, 0, 1, 2'd0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 0, 1, 2'b11);
    vecs[11] = mk(0, 0, 0, 2'd3, 0, 0, 1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2, 0, 1, 2'b11);
    vecs[12] = mk(0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 0, 1, 2'b11);
    vecs[13] = mk(0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 1, 1, 2'b11);
    vecs[14] = mk(0, 1, 0, 2'd0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 1, 1, 2'b11);
    vecs[15] = mk(0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 1, 1, 2'b11);
    vecs[16] = mk(0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 1, 1, 2'b11);

    drive(0, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", obs(), {2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 2'b00});
    @(negedge clk);
    reset = 1'b1;

    // Table-driven directed sequence
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fs, vecs[i].fc, vecs[i].fav, vecs[i].faf,
            vecs[i].bs, vecs[i].bc, vecs[i].bav, vecs[i].baf);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), obs(), vecs[i].expv);
    end

    // Bring forward count to 1, then reset between edges
    drive(1, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    @(posedge clk);
    #1 check("pre_async_reset", obs(), {2'd1, 2'd2, 2'd1, 2'd2, 1'b1, 1'b1, 2'b11});
    drive(0, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    #2 reset = 1'b0;
    #1 check("async_reset_no_edge", obs(), {2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 2'b00});
    #2 reset = 1'b1;
    drive(1, 0, 0, 2'd0, 0, 0, 0, 2'd0);
    @(posedge clk);
    #1 check("resume_after_reset", obs(), {2'd1, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 2'b00});

    // Randomized run against the reference model
    model_reset();
    m_fcnt = 1;
    for (int i = 0; i < 400; i++) begin
      logic fs, fc, fav, bs, bc, bav;
      logic [1:0] faf, baf;
      fs = 1'($urandom_range(0, 1)); fc = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1)); bc = 1'($urandom_range(0, 1));
      fav = ($urandom_range(0, 3) == 0); bav = ($urandom_range(0, 3) == 0);
      faf = 2'($urandom_range(0, 3)); baf = 2'($urandom_range(0, 3));
      if (i == 200) begin
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
      end
      drive(fs, fc, fav, faf, bs, bc, bav, baf);
      @(posedge clk);
      model_step(fs, fc, fav, faf, bs, bc, bav, baf);
      #1 check($sformatf("rand%0d", i), obs(), model_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
